// File: rtl/vmem_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package : vmem_pkg
// Brief   : Shared frame geometry, state encoding and pixel word layout.
// Rev     : 1.0
// ============================================================================
package vmem_pkg;

    localparam int WIDTH       = 34;
    localparam int HEIGHT      = 33;
    localparam int DATA_W      = 3;
    localparam int ADDR_W      = 11;
    localparam int XY_W        = 6;
    localparam int FRAME_WORDS = WIDTH * HEIGHT;
    localparam int PIX_W       = 2 * XY_W + DATA_W;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [XY_W-1:0]   X_LAST    = XY_W'(WIDTH - 1);
    localparam logic [XY_W-1:0]   Y_LAST    = XY_W'(HEIGHT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    typedef struct packed {
        logic [XY_W-1:0]   x;
        logic [XY_W-1:0]   y;
        logic [DATA_W-1:0] colour;
    } pix_t;

endpackage
`default_nettype wire

// File: rtl/vmem_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Interface : vmem_scan_reader_if
// Brief     : Pixel stream (colour + x/y) with valid/ready handshake.
// Rev       : 1.0
// ============================================================================
interface vmem_scan_reader_if;
    import vmem_pkg::*;

    logic [DATA_W-1:0] pix_data;
    logic [XY_W-1:0]   pix_x;
    logic [XY_W-1:0]   pix_y;
    logic              pix_valid;
    logic              pix_ready;

    modport master (output pix_data, output pix_x, output pix_y, output pix_valid,
                    input  pix_ready);
    modport slave  (input  pix_data, input  pix_x, input  pix_y, input  pix_valid,
                    output pix_ready);
endinterface
`default_nettype wire

// File: rtl/vmem_scan_reader_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : vmem_skid_buf
// Brief  : Two-entry valid/ready buffer for pixel words; exposes occupancy.
// Rev    : 1.0
// ============================================================================
module vmem_skid_buf
    import vmem_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_push,
    input  wire [PIX_W-1:0]  i_word,
    input  wire              i_pop,
    output logic             o_valid,
    output logic [PIX_W-1:0] o_word,
    output logic [1:0]       o_occ
);

    logic [PIX_W-1:0] r_slot [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop = i_pop & (r_count != 2'd0);

    // Upstream credit keeps pushes away from a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (i_push) begin
                r_slot[r_wr_ptr] <= i_word;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_word  = r_slot[r_rd_ptr];
    assign o_occ   = r_count;

endmodule
`default_nettype wire

// File: rtl/vmem_scan_reader.sv
`default_nettype none
// ============================================================================
// Module : vmem_scan_reader
// Brief  : Walks videoMem in raster order and streams pixels over valid/ready.
// Rev    : 1.0
// ============================================================================
module vmem_scan_reader
    import vmem_pkg::*;
(
    input  wire                Clck,
    input  wire                Resetn,
    input  wire                in_cont_signal,
    output logic               out_cont_signal,
    input  wire                next_out_cont_signal,
    output logic [ADDR_W-1:0]  mem_address,
    input  wire  [DATA_W-1:0]  mem_q,
    output logic               busy,
    vmem_scan_reader_if.master pix
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [XY_W-1:0]   r_x;
    logic [XY_W-1:0]   r_y;
    logic              r_inflight;
    logic [XY_W-1:0]   r_fl_x;
    logic [XY_W-1:0]   r_fl_y;
    logic              r_out_cont;

    logic [1:0]        w_occ;
    logic              w_head_valid;
    logic              w_pop;
    logic [2:0]        w_pending;
    logic              w_issue;
    logic              w_last_pop;
    pix_t              w_push_word;
    pix_t              w_head;

    // A pop this cycle frees a slot, which keeps one pixel per cycle with ready held high.
    assign w_pop       = w_head_valid & pix.pix_ready;
    assign w_pending   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == c_READ) && (w_pending < 3'd2);
    assign w_last_pop  = w_pop && (w_head.x == X_LAST) && (w_head.y == Y_LAST);
    assign w_push_word = {r_fl_x, r_fl_y, mem_q};

    vmem_skid_buf u_skid (
        .clk     (Clck),
        .rst_n   (Resetn),
        .i_push  (r_inflight),
        .i_word  (w_push_word),
        .i_pop   (w_pop),
        .o_valid (w_head_valid),
        .o_word  (w_head),
        .o_occ   (w_occ)
    );

    always_ff @(posedge Clck or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= c_IDLE;
            r_out_cont <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE:  if (in_cont_signal) r_state <= c_READ;
                c_READ:  if (w_issue && (r_addr == ADDR_LAST)) r_state <= c_DRAIN;
                c_DRAIN: if (w_last_pop) begin
                    r_state    <= c_DONE;
                    r_out_cont <= 1'b1;
                end
                c_DONE:  if (next_out_cont_signal) begin
                    r_state    <= c_IDLE;
                    r_out_cont <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Counters rewind on the final issue so the next frame starts at address 0.
    always_ff @(posedge Clck or negedge Resetn) begin
        if (!Resetn) begin
            r_addr     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_fl_x     <= '0;
            r_fl_y     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fl_x <= r_x;
                r_fl_y <= r_y;
                if (r_addr == ADDR_LAST) begin
                    r_addr <= '0;
                    r_x    <= '0;
                    r_y    <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + XY_W'(1);
                    end else begin
                        r_x <= r_x + XY_W'(1);
                    end
                end
            end
        end
    end

    assign mem_address     = r_addr;
    assign out_cont_signal = r_out_cont;
    assign busy            = (r_state != c_IDLE);
    assign pix.pix_valid   = w_head_valid;
    assign pix.pix_x       = w_head.x;
    assign pix.pix_y       = w_head.y;
    assign pix.pix_data    = w_head.colour;

endmodule
`default_nettype wire

// File: tb/tb_vmem_scan_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_vmem_scan_reader
// Brief  : Directed self-checking bench for vmem_scan_reader.
// Rev    : 1.0
// ============================================================================
module tb_vmem_scan_reader;
    import vmem_pkg::*;

    localparam int c_FRAME = FRAME_WORDS;

    logic              Clck = 1'b0;
    logic              Resetn = 1'b0;
    logic              in_cont_signal = 1'b0;
    logic              next_out_cont_signal = 1'b0;
    logic              out_cont_signal;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_q = '0;

    vmem_scan_reader_if pix_if ();

    vmem_scan_reader dut (
        .Clck                 (Clck),
        .Resetn               (Resetn),
        .in_cont_signal       (in_cont_signal),
        .out_cont_signal      (out_cont_signal),
        .next_out_cont_signal (next_out_cont_signal),
        .mem_address          (mem_address),
        .mem_q                (mem_q),
        .busy                 (busy),
        .pix                  (pix_if)
    );

    always #5 Clck = ~Clck;

    // Memory model: word content is the low three address bits, latency one.
    always @(posedge Clck) mem_q <= mem_address[2:0];

    int passed = 0;
    int total  = 0;

    int n_xfer, first_valid, first_xfer, last_xfer, out_cyc, out_high;
    int stab_err, vis_err, addr_err, max_out, busy_gap;
    bit frame_timeout;
    int cap_x [c_FRAME];
    int cap_y [c_FRAME];
    int cap_d [c_FRAME];

    // mode 0: ready=1, mode 1: ready 1-of-3, mode 2: 50-cycle stall at (10,5)
    task automatic run_frame(input int mode, input bit hold_next, input bit pulses);
        int c, prev_addr, issued, stall_left;
        bit wrapped, stall_done, prev_stall;
        logic [PIX_W-1:0] prev_word;
        n_xfer = 0; first_valid = -1; first_xfer = -1; last_xfer = -1;
        out_cyc = -1; out_high = 0; stab_err = 0; vis_err = 0; addr_err = 0;
        max_out = 0; busy_gap = 0; frame_timeout = 1'b1;
        prev_addr = 0; wrapped = 0; stall_left = 0; stall_done = 0; prev_stall = 0;
        prev_word = '0;
        for (int i = 0; i < c_FRAME; i++) begin
            cap_x[i] = -1; cap_y[i] = -1; cap_d[i] = -1;
        end
        next_out_cont_signal = hold_next;
        in_cont_signal = 1'b1;
        @(posedge Clck); #1;
        in_cont_signal = 1'b0;
        for (c = 0; c < 8000; c++) begin
            if (prev_stall && (!pix_if.pix_valid ||
                {pix_if.pix_x, pix_if.pix_y, pix_if.pix_data} !== prev_word)) stab_err++;
            if (pix_if.pix_valid && (!busy || out_cont_signal)) vis_err++;
            if (pix_if.pix_valid && first_valid < 0) first_valid = c;
            if (int'(mem_address) != prev_addr) begin
                if (prev_addr == c_FRAME - 1 && mem_address == '0) wrapped = 1;
                else if (int'(mem_address) != prev_addr + 1) addr_err++;
            end
            prev_addr = int'(mem_address);
            issued = wrapped ? c_FRAME : int'(mem_address);
            if (issued - n_xfer > max_out) max_out = issued - n_xfer;
            if (out_cont_signal) begin
                out_high++;
                if (out_cyc < 0) out_cyc = c;
            end
            if (!busy) begin
                if (out_cyc >= 0) begin
                    frame_timeout = 1'b0;
                    break;
                end
                busy_gap++;
            end
            if (!hold_next) next_out_cont_signal = (out_cyc >= 0 && c == out_cyc + 99);
            in_cont_signal = pulses && (c == 100 || (out_cyc >= 0 && c == out_cyc + 50));
            case (mode)
                0: pix_if.pix_ready = 1'b1;
                1: pix_if.pix_ready = (c % 3 == 0);
                default: begin
                    if (pix_if.pix_valid && !stall_done && pix_if.pix_x == 6'd10 && pix_if.pix_y == 6'd5) begin
                        stall_left = 50;
                        stall_done = 1;
                    end
                    pix_if.pix_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                if (n_xfer < c_FRAME) begin
                    cap_x[n_xfer] = int'(pix_if.pix_x);
                    cap_y[n_xfer] = int'(pix_if.pix_y);
                    cap_d[n_xfer] = int'(pix_if.pix_data);
                end
                if (first_xfer < 0) first_xfer = c;
                last_xfer = c;
                n_xfer++;
            end
            prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
            prev_word  = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_data};
            @(posedge Clck); #1;
        end
        next_out_cont_signal = 1'b0;
        in_cont_signal = 1'b0;
        pix_if.pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (out_cont_signal !== 1'b0) $display("FAIL reset_out_cont: got %b want 0", out_cont_signal); else passed++;
        total++; if (pix_if.pix_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pix_if.pix_valid); else passed++;
        total++; if (mem_address !== '0) $display("FAIL reset_addr: got %0d want 0", mem_address); else passed++;
        total++; if ({pix_if.pix_x, pix_if.pix_y, pix_if.pix_data} !== '0)
            $display("FAIL reset_pix: got x=%0d y=%0d d=%0d want 0", pix_if.pix_x, pix_if.pix_y, pix_if.pix_data);
        else passed++;
    endtask

    task automatic test_full_frame();
        int errs;
        run_frame(0, 1'b1, 1'b0);
        errs = 0;
        for (int i = 0; i < c_FRAME; i++)
            if (cap_x[i] != i % WIDTH || cap_y[i] != i / WIDTH || cap_d[i] != i % 8) errs++;
        total++; if (frame_timeout) $display("FAIL full_timeout: frame did not complete"); else passed++;
        total++; if (n_xfer != c_FRAME) $display("FAIL full_count: got %0d want %0d", n_xfer, c_FRAME); else passed++;
        total++; if (errs != 0) $display("FAIL full_sequence: got %0d bad pixels want 0", errs); else passed++;
        total++; if (cap_x[c_FRAME-1] != 33 || cap_y[c_FRAME-1] != 32)
            $display("FAIL full_last_xy: got (%0d,%0d) want (33,32)", cap_x[c_FRAME-1], cap_y[c_FRAME-1]);
        else passed++;
        total++; if (first_valid != 2) $display("FAIL full_latency: got %0d want 2", first_valid); else passed++;
        total++; if (last_xfer - first_xfer != c_FRAME - 1)
            $display("FAIL full_back_to_back: got span %0d want %0d", last_xfer - first_xfer, c_FRAME - 1);
        else passed++;
        total++; if (out_cyc != last_xfer + 1) $display("FAIL full_out_cont_time: got %0d want %0d", out_cyc, last_xfer + 1); else passed++;
        total++; if (out_high != 1) $display("FAIL full_out_cont_width: got %0d want 1", out_high); else passed++;
        total++; if (addr_err != 0) $display("FAIL full_addr_order: got %0d errors want 0", addr_err); else passed++;
        total++; if (vis_err != 0) $display("FAIL full_valid_idle: got %0d want 0", vis_err); else passed++;
    endtask

    task automatic test_stall_pattern();
        int errs;
        run_frame(1, 1'b1, 1'b0);
        errs = 0;
        for (int i = 0; i < c_FRAME; i++)
            if (cap_x[i] != i % WIDTH || cap_y[i] != i / WIDTH || cap_d[i] != i % 8) errs++;
        total++; if (n_xfer != c_FRAME) $display("FAIL toggle_count: got %0d want %0d", n_xfer, c_FRAME); else passed++;
        total++; if (errs != 0) $display("FAIL toggle_sequence: got %0d bad pixels want 0", errs); else passed++;
        total++; if (stab_err != 0) $display("FAIL toggle_stable: got %0d unstable cycles want 0", stab_err); else passed++;
        total++; if (max_out > 2) $display("FAIL toggle_credit: got %0d outstanding want <=2", max_out); else passed++;
    endtask

    task automatic test_mid_row_stall();
        int errs;
        run_frame(2, 1'b1, 1'b0);
        errs = 0;
        for (int i = 0; i < c_FRAME; i++)
            if (cap_x[i] != i % WIDTH || cap_y[i] != i / WIDTH || cap_d[i] != i % 8) errs++;
        total++; if (errs != 0 || n_xfer != c_FRAME)
            $display("FAIL stall_sequence: got %0d bad pixels, %0d transfers want 0, %0d", errs, n_xfer, c_FRAME);
        else passed++;
        total++; if (max_out != 2) $display("FAIL stall_outstanding: got %0d want 2", max_out); else passed++;
        total++; if (stab_err != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", stab_err); else passed++;
        total++; if (cap_x[180] != 10 || cap_y[180] != 5 || cap_x[181] != 11 || cap_y[181] != 5)
            $display("FAIL stall_resume: got (%0d,%0d),(%0d,%0d) want (10,5),(11,5)",
                     cap_x[180], cap_y[180], cap_x[181], cap_y[181]);
        else passed++;
    endtask

    task automatic test_ignore_restart();
        int seen;
        run_frame(0, 1'b0, 1'b1);
        total++; if (n_xfer != c_FRAME) $display("FAIL restart_count: got %0d want %0d", n_xfer, c_FRAME); else passed++;
        total++; if (busy_gap != 0) $display("FAIL restart_busy: got %0d idle cycles want 0", busy_gap); else passed++;
        total++; if (out_high != 100) $display("FAIL restart_out_hold: got %0d want 100", out_high); else passed++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || pix_if.pix_valid || out_cont_signal) seen++;
            @(posedge Clck); #1;
        end
        total++; if (seen != 0) $display("FAIL restart_second_frame: got %0d active cycles want 0", seen); else passed++;
    endtask

    task automatic test_reset_abort();
        int n, errs;
        n = 0;
        pix_if.pix_ready = 1'b1;
        in_cont_signal = 1'b1;
        @(posedge Clck); #1;
        in_cont_signal = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (pix_if.pix_valid && pix_if.pix_ready) n++;
            if (n == 500) break;
            @(posedge Clck); #1;
        end
        total++; if (n != 500) $display("FAIL abort_reach: got %0d transfers want 500", n); else passed++;
        #2 Resetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || out_cont_signal !== 1'b0 || pix_if.pix_valid !== 1'b0)
            $display("FAIL abort_async_ctrl: got busy=%b out=%b valid=%b want 0", busy, out_cont_signal, pix_if.pix_valid);
        else passed++;
        total++; if (mem_address !== '0 || {pix_if.pix_x, pix_if.pix_y, pix_if.pix_data} !== '0)
            $display("FAIL abort_async_data: got addr=%0d x=%0d y=%0d d=%0d want 0",
                     mem_address, pix_if.pix_x, pix_if.pix_y, pix_if.pix_data);
        else passed++;
        pix_if.pix_ready = 1'b0;
        @(posedge Clck); #1;
        Resetn = 1'b1;
        @(posedge Clck); #1;
        total++; if (busy !== 1'b0 || out_cont_signal !== 1'b0)
            $display("FAIL abort_no_cont: got busy=%b out=%b want 0", busy, out_cont_signal);
        else passed++;
        run_frame(0, 1'b1, 1'b0);
        errs = 0;
        for (int i = 0; i < c_FRAME; i++)
            if (cap_x[i] != i % WIDTH || cap_y[i] != i / WIDTH || cap_d[i] != i % 8) errs++;
        total++; if (cap_x[0] != 0 || cap_y[0] != 0 || cap_d[0] != 0)
            $display("FAIL abort_first_pixel: got (%0d,%0d,%0d) want (0,0,0)", cap_x[0], cap_y[0], cap_d[0]);
        else passed++;
        total++; if (n_xfer != c_FRAME || errs != 0 || addr_err != 0)
            $display("FAIL abort_refill: got %0d transfers, %0d bad, %0d addr errors want %0d,0,0",
                     n_xfer, errs, addr_err, c_FRAME);
        else passed++;
    endtask

    initial begin
        pix_if.pix_ready = 1'b0;
        repeat (3) @(posedge Clck);
        #1;
        test_reset();
        Resetn = 1'b1;
        @(posedge Clck); #1;
        test_full_frame();
        test_stall_pattern();
        test_mid_row_stall();
        test_ignore_restart();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
